instr_fetch_unit: RTL and testbench

- Supplies the instruction register (IR) to the processor control unit.
- Owns the program counter (PC) and consumes the control unit's ir_load and pc_load strobes.
- Fetches one opcode byte per request from program memory over a req/ack handshake.
- Signals fetch progress, aborts stalled fetches by timeout, and injects a NOP so the control unit falls back to START.

---
 rtl/instr_fetch_unit_pkg.sv | 15 +
 rtl/fetch_pc_reg.sv | 37 +++
 rtl/instr_fetch_unit.sv | 128 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit and its neighbours
// (control unit, ALU): default widths, FSM state type and the NOP opcode.
package instr_fetch_unit_pkg;

    localparam int unsigned ADDR_W_DEF  = 8;
    localparam int unsigned INSTR_W_DEF = 8;

    localparam logic [7:0] NOP_OPCODE = 8'h00;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register: jump load has priority over increment,
// increment wraps modulo 2^ADDR_W.
module fetch_pc_reg #(
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned RESET_PC = 0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              jump_en_i,
    input  logic [ADDR_W-1:0] jump_addr_i,
    input  logic              pc_load_i,
    output logic [ADDR_W-1:0] pc_o
);

    logic [ADDR_W-1:0] pc_d;
    logic [ADDR_W-1:0] pc_q;

    always_comb begin
        pc_d = pc_q;
        if (jump_en_i) begin
            pc_d = jump_addr_i;
        end else if (pc_load_i) begin
            pc_d = pc_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_q <= ADDR_W'(RESET_PC);
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: fetches one opcode per ir_load over a req/ack
// handshake, aborting with a NOP and an error pulse when memory stalls.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int unsigned ADDR_W      = ADDR_W_DEF,
    parameter int unsigned INSTR_W     = INSTR_W_DEF,
    parameter int unsigned RESET_PC    = 0,
    parameter int unsigned ACK_TIMEOUT = 15
) (
    input  logic               clock_i,
    input  logic               reset_i,
    input  logic               ir_load_i,
    input  logic               pc_load_i,
    input  logic               jump_en_i,
    input  logic [ADDR_W-1:0]  jump_addr_i,
    output logic               mem_req_o,
    output logic [ADDR_W-1:0]  mem_addr_o,
    input  logic [INSTR_W-1:0] mem_rdata_i,
    input  logic               mem_ack_i,
    output logic [INSTR_W-1:0] ir_o,
    output logic               ir_valid_o,
    output logic [ADDR_W-1:0]  pc_o,
    output logic               busy_o,
    output logic               fetch_err_o
);

    localparam int unsigned CNT_W = $clog2(ACK_TIMEOUT + 1);

    fetch_state_e       state_d,      state_q;
    logic [ADDR_W-1:0]  fetch_addr_d, fetch_addr_q;
    logic [CNT_W-1:0]   cnt_d,        cnt_q;
    logic [INSTR_W-1:0] ir_d,         ir_q;
    logic               ir_valid_d,   ir_valid_q;
    logic               mem_req_d,    mem_req_q;
    logic               busy_d,       busy_q;
    logic               fetch_err_d,  fetch_err_q;
    logic [ADDR_W-1:0]  pc;

    fetch_pc_reg #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk_i       (clock_i),
        .rst_i       (reset_i),
        .jump_en_i   (jump_en_i),
        .jump_addr_i (jump_addr_i),
        .pc_load_i   (pc_load_i),
        .pc_o        (pc)
    );

    // Next-state and registered-output logic; ack beats a same-cycle timeout.
    always_comb begin
        state_d      = state_q;
        fetch_addr_d = fetch_addr_q;
        cnt_d        = cnt_q;
        ir_d         = ir_q;
        ir_valid_d   = ir_valid_q;
        mem_req_d    = mem_req_q;
        busy_d       = busy_q;
        fetch_err_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (ir_load_i) begin
                    fetch_addr_d = pc;
                    mem_req_d    = 1'b1;
                    busy_d       = 1'b1;
                    ir_valid_d   = 1'b0;
                    cnt_d        = '0;
                    state_d      = REQ;
                end
            end
            REQ: begin
                if (mem_ack_i) begin
                    ir_d       = mem_rdata_i;
                    ir_valid_d = 1'b1;
                    mem_req_d  = 1'b0;
                    busy_d     = 1'b0;
                    state_d    = IDLE;
                end else if (cnt_q == CNT_W'(ACK_TIMEOUT - 1)) begin
                    ir_d        = INSTR_W'(NOP_OPCODE);
                    ir_valid_d  = 1'b1;
                    fetch_err_d = 1'b1;
                    mem_req_d   = 1'b0;
                    busy_d      = 1'b0;
                    state_d     = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= IDLE;
            fetch_addr_q <= '0;
            cnt_q        <= '0;
            ir_q         <= '0;
            ir_valid_q   <= 1'b0;
            mem_req_q    <= 1'b0;
            busy_q       <= 1'b0;
            fetch_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_addr_q <= fetch_addr_d;
            cnt_q        <= cnt_d;
            ir_q         <= ir_d;
            ir_valid_q   <= ir_valid_d;
            mem_req_q    <= mem_req_d;
            busy_q       <= busy_d;
            fetch_err_q  <= fetch_err_d;
        end
    end

    assign mem_req_o   = mem_req_q;
    assign mem_addr_o  = fetch_addr_q;
    assign ir_o        = ir_q;
    assign ir_valid_o  = ir_valid_q;
    assign pc_o        = pc;
    assign busy_o      = busy_q;
    assign fetch_err_o = fetch_err_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit (default parameters,
// ACK_TIMEOUT = 15).
module tb_instr_fetch_unit;

    logic       clock;
    logic       reset;
    logic       ir_load;
    logic       pc_load;
    logic       jump_en;
    logic [7:0] jump_addr;
    logic       mem_req;
    logic [7:0] mem_addr;
    logic [7:0] mem_rdata;
    logic       mem_ack;
    logic [7:0] ir;
    logic       ir_valid;
    logic [7:0] pc;
    logic       busy;
    logic       fetch_err;

    int checks;
    int failures;

    instr_fetch_unit dut (
        .clock_i     (clock),
        .reset_i     (reset),
        .ir_load_i   (ir_load),
        .pc_load_i   (pc_load),
        .jump_en_i   (jump_en),
        .jump_addr_i (jump_addr),
        .mem_req_o   (mem_req),
        .mem_addr_o  (mem_addr),
        .mem_rdata_i (mem_rdata),
        .mem_ack_i   (mem_ack),
        .ir_o        (ir),
        .ir_valid_o  (ir_valid),
        .pc_o        (pc),
        .busy_o      (busy),
        .fetch_err_o (fetch_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // One clock; outputs are sampled 1ns after the rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        int n;
        int err_seen;
        int rises;
        logic prev_req;

        checks    = 0;
        failures  = 0;
        reset     = 1'b1;
        ir_load   = 1'b0;
        pc_load   = 1'b0;
        jump_en   = 1'b0;
        jump_addr = 8'h00;
        mem_rdata = 8'h00;
        mem_ack   = 1'b0;

        tick();
        tick();
        check("rst_pc",        32'(pc),        32'h00);
        check("rst_ir",        32'(ir),        32'h00);
        check("rst_ir_valid",  32'(ir_valid),  32'h0);
        check("rst_mem_req",   32'(mem_req),   32'h0);
        check("rst_mem_addr",  32'(mem_addr),  32'h00);
        check("rst_busy",      32'(busy),      32'h0);
        check("rst_fetch_err", 32'(fetch_err), 32'h0);
        reset = 1'b0;

        // Basic fetch, ack two cycles after the request rises.
        ir_load = 1'b1;
        tick();
        ir_load = 1'b0;
        check("f1_req",  32'(mem_req),  32'h1);
        check("f1_addr", 32'(mem_addr), 32'h00);
        check("f1_busy", 32'(busy),     32'h1);
        tick();
        mem_ack = 1'b1; mem_rdata = 8'h01;
        tick();
        mem_ack = 1'b0;
        check("f1_ir",        32'(ir),        32'h01);
        check("f1_ir_valid",  32'(ir_valid),  32'h1);
        check("f1_busy_done", 32'(busy),      32'h0);
        check("f1_req_done",  32'(mem_req),   32'h0);
        check("f1_fetch_err", 32'(fetch_err), 32'h0);

        // PC wrap and jump-over-increment priority.
        jump_en = 1'b1; jump_addr = 8'hFF;
        tick();
        jump_en = 1'b0;
        check("pc_jump_ff", 32'(pc), 32'hFF);
        pc_load = 1'b1;
        tick();
        pc_load = 1'b0;
        check("pc_wrap", 32'(pc), 32'h00);
        jump_en = 1'b1; jump_addr = 8'h40; pc_load = 1'b1;
        tick();
        jump_en = 1'b0; pc_load = 1'b0;
        check("pc_jump_prio", 32'(pc), 32'h40);

        // Jump during REQ must not disturb mem_addr.
        jump_en = 1'b1; jump_addr = 8'h10;
        tick();
        jump_en = 1'b0;
        ir_load = 1'b1;
        tick();
        ir_load = 1'b0;
        check("j_addr_start", 32'(mem_addr), 32'h10);
        jump_en = 1'b1; jump_addr = 8'h80;
        tick();
        jump_en = 1'b0;
        check("j_addr_held", 32'(mem_addr), 32'h10);
        check("j_pc_moved",  32'(pc),       32'h80);
        tick();
        check("j_addr_held2", 32'(mem_addr), 32'h10);
        mem_ack = 1'b1; mem_rdata = 8'h5C;
        tick();
        mem_ack = 1'b0;
        check("j_ir",     32'(ir),      32'h5C);
        check("j_pc",     32'(pc),      32'h80);
        check("j_req_lo", 32'(mem_req), 32'h0);

        // Timeout: request held for 15 cycles, then NOP plus one error pulse.
        ir_load = 1'b1;
        tick();
        ir_load = 1'b0;
        n = 0;
        err_seen = 0;
        while (mem_req && n < 40) begin
            n++;
            if (fetch_err) err_seen++;
            tick();
        end
        check("to_req_cycles",   32'(n),         32'd15);
        check("to_err_early",    32'(err_seen),  32'd0);
        check("to_fetch_err",    32'(fetch_err), 32'h1);
        check("to_ir_nop",       32'(ir),        32'h00);
        check("to_ir_valid",     32'(ir_valid),  32'h1);
        check("to_busy",         32'(busy),      32'h0);
        tick();
        check("to_err_one_shot", 32'(fetch_err), 32'h0);

        // Ack on the final REQ cycle wins over the timeout.
        ir_load = 1'b1;
        tick();
        ir_load = 1'b0;
        repeat (14) tick();
        check("late_req_still", 32'(mem_req), 32'h1);
        mem_ack = 1'b1; mem_rdata = 8'h3E;
        tick();
        mem_ack = 1'b0;
        check("late_ir",        32'(ir),        32'h3E);
        check("late_ir_valid",  32'(ir_valid),  32'h1);
        check("late_no_err",    32'(fetch_err), 32'h0);
        check("late_req_lo",    32'(mem_req),   32'h0);
        tick();
        check("late_no_err2",   32'(fetch_err), 32'h0);

        // Asynchronous reset mid-REQ; a later ack must be ignored.
        ir_load = 1'b1;
        tick();
        ir_load = 1'b0;
        tick();
        check("rr_req_before", 32'(mem_req), 32'h1);
        reset = 1'b1;
        #1;
        check("rr_req_async",  32'(mem_req),  32'h0);
        check("rr_ir",         32'(ir),       32'h00);
        check("rr_ir_valid",   32'(ir_valid), 32'h0);
        check("rr_busy",       32'(busy),     32'h0);
        check("rr_pc",         32'(pc),       32'h00);
        reset = 1'b0; mem_ack = 1'b1; mem_rdata = 8'h77;
        tick();
        mem_ack = 1'b0;
        check("rr_ack_ign_ir",  32'(ir),       32'h00);
        check("rr_ack_ign_vld", 32'(ir_valid), 32'h0);
        check("rr_ack_ign_req", 32'(mem_req),  32'h0);

        // Spurious ack in IDLE, then ir_load held through REQ: one request only.
        mem_ack = 1'b1; mem_rdata = 8'hAA;
        tick();
        mem_ack = 1'b0;
        check("sp_ir",       32'(ir),       32'h00);
        check("sp_ir_valid", 32'(ir_valid), 32'h0);
        rises = 0;
        prev_req = mem_req;
        ir_load = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (mem_req && !prev_req) rises++;
            prev_req = mem_req;
        end
        ir_load = 1'b0;
        mem_ack = 1'b1; mem_rdata = 8'h21;
        tick();
        mem_ack = 1'b0;
        check("sp_req_rises", 32'(rises), 32'd1);
        check("sp_ir_fetch",  32'(ir),    32'h21);

        // ir_load with pc_load in the same IDLE cycle fetches the old pc.
        jump_en = 1'b1; jump_addr = 8'h20;
        tick();
        jump_en = 1'b0;
        ir_load = 1'b1; pc_load = 1'b1;
        tick();
        ir_load = 1'b0; pc_load = 1'b0;
        check("ipc_addr", 32'(mem_addr), 32'h20);
        check("ipc_pc",   32'(pc),       32'h21);
        mem_ack = 1'b1; mem_rdata = 8'h9B;
        tick();
        mem_ack = 1'b0;
        check("ipc_ir", 32'(ir), 32'h9B);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
